// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the data port always wins.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_mem
);
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_e;
  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              en_q, en_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              if_ready_q, if_ready_d, d_ready_q, d_ready_d;
  logic              d_req, grant_d;
  assign d_req = d_read || d_write;
`ifdef ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;
  // On a tie, the port that did not win last time goes first.
  assign grant_d = d_req && !(if_req && last_d_q);
  always_ff @(posedge clk)
    if (reset) last_d_q <= 1'b0;
    else last_d_q <= last_d_d;
  always_comb begin
    last_d_d = last_d_q;
    if (state_q == IDLE && (d_req || if_req)) last_d_d = grant_d;
  end
`else
  assign grant_d = d_req;
`endif
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    en_d       = en_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_ready_d = 1'b0;
    d_ready_d  = 1'b0;
    unique case (state_q)
      IDLE: if (d_req || if_req) begin
        state_d = ACCESS;
        owner_d = grant_d ? OWN_D : OWN_IF;
        addr_d  = grant_d ? d_addr : if_addr;
        wdata_d = grant_d ? d_wdata : wdata_q;
        we_d    = grant_d && d_write;
        en_d    = 1'b1;
        cnt_d   = CW'(MEM_LATENCY - 1);
      end
      ACCESS: begin
        cnt_d = cnt_q == '0 ? '0 : cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d    = DONE;
          en_d       = 1'b0;
          we_d       = 1'b0;
          if_ready_d = owner_q == OWN_IF;
          d_ready_d  = owner_q == OWN_D;
          if (!we_q && owner_q == OWN_IF) if_rdata_d = mem_rdata;
          if (!we_q && owner_q == OWN_D) d_rdata_d = mem_rdata;
        end
      end
      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= OWN_NONE;
      cnt_q      <= '0;
      en_q       <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      en_q       <= en_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_ready_q <= if_ready_d;
      d_ready_q  <= d_ready_d;
    end
  end
  assign mem_en    = en_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ready  = if_ready_q;
  assign d_ready   = d_ready_q;
  assign stall_if  = if_req && !if_ready_q;
  assign stall_mem = d_req && !d_ready_q;
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the IF stage (instruction fetch, read-only) and the MEM stage (LW/SW data access).
- Sequences each access through a small FSM and returns read data with a one-cycle ready pulse.
- Generates per-stage stall signals for the pipeline hazard logic.
- Sits between the pipeline stage registers and the memory macro.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- MEM_LATENCY, 2, cycles mem_en/address must be held before mem_rdata is valid. Legal values are 1 to 15.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, valid when if_ready=1
- if_ready  out  1  one-cycle pulse: fetch complete
- d_read  in  1  data read request (Memread), held until d_ready
- d_write  in  1  data write request (MemWrite), held until d_ready
- d_addr  in  ADDR_W  data address (ALU result)
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, valid when d_ready=1
- d_ready  out  1  one-cycle pulse: data access complete
- mem_en  out  1  memory access enable
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid in the last ACCESS cycle
- stall_if  out  1  if_req && !if_ready (combinational)
- stall_mem  out  1  (d_read||d_write) && !d_ready (combinational)

Behaviour:
- States: IDLE, ACCESS, DONE. Owner register: NONE, IF or D.
- Reset (synchronous, all registered outputs):
  - state=IDLE, owner=NONE.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_ready=0, d_ready=0, if_rdata=0, d_rdata=0, latency counter=0.
- IDLE, arbitration:
  - If d_read or d_write is high, grant D.
  - Otherwise, if if_req is high, grant IF.
  - Otherwise, stay in IDLE.
- Grant (on the IDLE cycle, registered):
  - Latch address and write data into mem_addr/mem_wdata.
  - mem_we = d_write for a D grant, 0 for an IF grant.
  - mem_en=1, counter=MEM_LATENCY-1, go to ACCESS.
- ACCESS:
  - Hold mem_en, mem_we, mem_addr, mem_wdata stable.
  - Decrement the counter each cycle.
  - In the cycle where counter==0:
    - Capture mem_rdata into the owner's rdata register (skipped on a write; rdata keeps its old value).
    - Next state DONE; mem_en=0, mem_we=0.
- DONE:
  - Owner's ready=1 for exactly this one cycle. The non-owner's ready stays 0.
  - Next state IDLE, owner=NONE.
- Latency: request sampled in IDLE at cycle T.
  - mem_en is high for cycles T+1 to T+MEM_LATENCY.
  - ready is high at T+MEM_LATENCY+1.
  - The next grant occurs at T+MEM_LATENCY+2 at the earliest.
- Requesters drop or change their request in the cycle after ready. A request still high in the IDLE cycle after DONE is treated as a new access.
- d_read and d_write both high: treated as a write (mem_we=1). d_rdata is not updated.
- Address or data changes while a request is granted are ignored; latched values are used.
- A request arriving during ACCESS/DONE waits. Its stall output stays high until its own ready pulse.
- rdata registers hold their value until the next completed read for that port.
- Reset mid-ACCESS:
  - Access is abandoned; mem_en and mem_we drop on the reset edge.
  - No ready pulse is issued; requesters re-request after reset.
  - A partial write to the memory is not reported.
- The counter width fits MEM_LATENCY-1. MEM_LATENCY=1 gives exactly one ACCESS cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_owner register, reset to IF.
  - When both d_* and if_req are pending in IDLE, grant the port that was not last_owner. A lone request is always granted.
  - last_owner is updated on each grant.
- Undefined: fixed priority, data port always wins. A continuous data request can starve fetch; this is acceptable because the MEM stage stalls IF anyway.

Test Plan (MEM_LATENCY=2 unless noted):
- Reset, then if_req=1 with if_addr=0x0000_0040 and mem_rdata=0x8C22_0004 during ACCESS:
  - mem_en high for 2 cycles with mem_addr=0x40 and mem_we=0.
  - if_ready pulses 1 cycle with if_rdata=0x8C22_0004.
  - stall_if is high in every cycle before the pulse.
- d_write=1 with d_addr=0x100 and d_wdata=0xDEAD_BEEF:
  - mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF for 2 cycles.
  - d_ready pulses; d_rdata is unchanged.
- if_req and d_read asserted in the same cycle (macro off):
  - D is served first; d_ready at T+3.
  - IF is granted at T+4; if_ready at T+7.
  - stall_if is high T to T+6.
- Same stimulus held continuously with ARB_ROUND_ROBIN_EN defined: grants alternate D, IF, D, IF, starting with D because last_owner resets to IF.
- reset asserted in the second ACCESS cycle of a write:
  - mem_en=0, mem_we=0 in the next cycle.
  - No ready pulse; state IDLE.
  - A new if_req is served normally afterwards.
- MEM_LATENCY=1, d_read and d_write both high with d_addr=0x8: single ACCESS cycle with mem_we=1; d_ready at T+2.
